// File: rtl/apu_mix_sequencer.sv
// Game Boy APU frame sequencer (512 Hz step, length/sweep/envelope ticks) and stereo mixer
// presenting one sample pair per AC97 frame. Define APU_SIGNED_OUT_EN for two's complement output.
module apu_mix_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 4,
  parameter int FS_DIV     = 24000,
  parameter int SAMPLE_DIV = 256,
  parameter int OUT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_CH*CH_W-1:0] ch_level,
  input  logic [NUM_CH-1:0]      left_en,
  input  logic [NUM_CH-1:0]      right_en,
  input  logic [2:0]             left_vol,
  input  logic [2:0]             right_vol,
  output logic [2:0]             fs_step,
  output logic                   length_tick,
  output logic                   sweep_tick,
  output logic                   envelope_tick,
  output logic [OUT_W-1:0]       sample_left,
  output logic [OUT_W-1:0]       sample_right,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun
);

  localparam int SUM_W = CH_W + $clog2(NUM_CH);
  localparam int SW    = SUM_W + 3;
  localparam int SHIFT = OUT_W - SW;
  localparam int FS_CW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam int SD_CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCALE,
    ST_HOLD
  } state_t;

  // ---------------- frame sequencer ----------------
  logic [FS_CW-1:0] fs_cnt_q, fs_cnt_d;
  logic [2:0]       fs_step_q, fs_step_d;
  logic             length_tick_q, length_tick_d;
  logic             sweep_tick_q, sweep_tick_d;
  logic             envelope_tick_q, envelope_tick_d;

  always_comb begin
    fs_cnt_d        = fs_cnt_q;
    fs_step_d       = fs_step_q;
    length_tick_d   = 1'b0;
    sweep_tick_d    = 1'b0;
    envelope_tick_d = 1'b0;
    if (!enable) begin
      fs_cnt_d  = '0;
      fs_step_d = '0;
    end else if (fs_cnt_q == FS_CW'(FS_DIV - 1)) begin
      fs_cnt_d  = '0;
      fs_step_d = fs_step_q + 3'd1;
      // Ticks decode the step being entered, so they line up with the new fs_step
      length_tick_d   = ~fs_step_d[0];
      sweep_tick_d    = (fs_step_d[1:0] == 2'b10);
      envelope_tick_d = (fs_step_d == 3'd7);
    end else begin
      fs_cnt_d = fs_cnt_q + FS_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_cnt_q        <= '0;
      fs_step_q       <= '0;
      length_tick_q   <= 1'b0;
      sweep_tick_q    <= 1'b0;
      envelope_tick_q <= 1'b0;
    end else begin
      fs_cnt_q        <= fs_cnt_d;
      fs_step_q       <= fs_step_d;
      length_tick_q   <= length_tick_d;
      sweep_tick_q    <= sweep_tick_d;
      envelope_tick_q <= envelope_tick_d;
    end
  end

  // ---------------- sample-rate divider ----------------
  logic [SD_CW-1:0] sd_cnt_q, sd_cnt_d;
  logic             sample_tick;

  always_comb begin
    sample_tick = (sd_cnt_q == SD_CW'(SAMPLE_DIV - 1));
    sd_cnt_d    = sample_tick ? '0 : sd_cnt_q + SD_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_cnt_q <= '0;
    end else begin
      sd_cnt_q <= sd_cnt_d;
    end
  end

  // ---------------- mixer ----------------
  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       acc_idx_q, acc_idx_d;
  logic [NUM_CH*CH_W-1:0] lvl_sh_q, lvl_sh_d;
  logic [NUM_CH-1:0]      len_sh_q, len_sh_d;
  logic [NUM_CH-1:0]      ren_sh_q, ren_sh_d;
  logic [2:0]             lvol_q, lvol_d;
  logic [2:0]             rvol_q, rvol_d;
  logic                   en_snap_q, en_snap_d;
  logic [SUM_W-1:0]       sum_l_q, sum_l_d;
  logic [SUM_W-1:0]       sum_r_q, sum_r_d;
  logic [OUT_W-1:0]       sample_left_q, sample_left_d;
  logic [OUT_W-1:0]       sample_right_q, sample_right_d;
  logic                   overrun_q, overrun_d;
  logic                   take_snap;

  // Product width SW always holds sum*(vol+1); result is MSB-justified into OUT_W.
  function automatic logic [OUT_W-1:0] scale_lane(input logic [SUM_W-1:0] sum,
                                                  input logic [2:0] vol,
                                                  input logic en);
    logic [SW-1:0]    scaled;
    logic [OUT_W-1:0] res;
    scaled = SW'(sum) * SW'({1'b0, vol} + 4'd1);
    res    = OUT_W'(scaled) << SHIFT;
    if (!en) begin
      res = '0;
    end
`ifdef APU_SIGNED_OUT_EN
    res[OUT_W-1] = ~res[OUT_W-1];
`endif
    return res;
  endfunction

  always_comb begin
    state_d        = state_q;
    acc_idx_d      = acc_idx_q;
    lvl_sh_d       = lvl_sh_q;
    len_sh_d       = len_sh_q;
    ren_sh_d       = ren_sh_q;
    lvol_d         = lvol_q;
    rvol_d         = rvol_q;
    en_snap_d      = en_snap_q;
    sum_l_d        = sum_l_q;
    sum_r_d        = sum_r_q;
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    overrun_d      = overrun_q;
    take_snap      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          take_snap = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (sample_tick) begin
          overrun_d = 1'b1;
        end
        // Snapshot is consumed LSB-first, one channel per cycle
        if (len_sh_q[0]) begin
          sum_l_d = sum_l_q + SUM_W'(lvl_sh_q[CH_W-1:0]);
        end
        if (ren_sh_q[0]) begin
          sum_r_d = sum_r_q + SUM_W'(lvl_sh_q[CH_W-1:0]);
        end
        lvl_sh_d  = lvl_sh_q >> CH_W;
        len_sh_d  = len_sh_q >> 1;
        ren_sh_d  = ren_sh_q >> 1;
        acc_idx_d = acc_idx_q + IDX_W'(1);
        if (acc_idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        if (sample_tick) begin
          overrun_d = 1'b1;
        end
        sample_left_d  = scale_lane(sum_l_q, lvol_q, en_snap_q);
        sample_right_d = scale_lane(sum_r_q, rvol_q, en_snap_q);
        state_d        = ST_HOLD;
      end
      ST_HOLD: begin
        if (sample_ready) begin
          if (sample_tick) begin
            take_snap = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (sample_tick) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (take_snap) begin
      lvl_sh_d  = ch_level;
      len_sh_d  = left_en;
      ren_sh_d  = right_en;
      lvol_d    = left_vol;
      rvol_d    = right_vol;
      en_snap_d = enable;
      sum_l_d   = '0;
      sum_r_d   = '0;
      acc_idx_d = '0;
      state_d   = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      acc_idx_q      <= '0;
      lvl_sh_q       <= '0;
      len_sh_q       <= '0;
      ren_sh_q       <= '0;
      lvol_q         <= '0;
      rvol_q         <= '0;
      en_snap_q      <= 1'b0;
      sum_l_q        <= '0;
      sum_r_q        <= '0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_idx_q      <= acc_idx_d;
      lvl_sh_q       <= lvl_sh_d;
      len_sh_q       <= len_sh_d;
      ren_sh_q       <= ren_sh_d;
      lvol_q         <= lvol_d;
      rvol_q         <= rvol_d;
      en_snap_q      <= en_snap_d;
      sum_l_q        <= sum_l_d;
      sum_r_q        <= sum_r_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      overrun_q      <= overrun_d;
    end
  end

  assign fs_step       = fs_step_q;
  assign length_tick   = length_tick_q;
  assign sweep_tick    = sweep_tick_q;
  assign envelope_tick = envelope_tick_q;
  assign sample_left   = sample_left_q;
  assign sample_right  = sample_right_q;
  assign sample_valid  = (state_q == ST_HOLD);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_apu_mix_sequencer.sv
// Bench for apu_mix_sequencer: cycle-level reference model, sample scoreboard, directed and random phases.
module tb_apu_mix_sequencer;

  localparam int P_NUM_CH     = 4;
  localparam int P_CH_W       = 4;
  localparam int P_FS_DIV     = 4;
  localparam int P_SAMPLE_DIV = 8;
  localparam int P_OUT_W      = 16;
  localparam int SW           = P_CH_W + $clog2(P_NUM_CH) + 3;

`ifdef APU_SIGNED_OUT_EN
  localparam logic [15:0] EXP_A_L = 16'h7000;
  localparam logic [15:0] EXP_A_R = 16'h8000;
  localparam logic [15:0] EXP_B_L = 16'h8000;
  localparam logic [15:0] EXP_B_R = 16'h8280;
`else
  localparam logic [15:0] EXP_A_L = 16'hF000;
  localparam logic [15:0] EXP_A_R = 16'h0000;
  localparam logic [15:0] EXP_B_L = 16'h0000;
  localparam logic [15:0] EXP_B_R = 16'h0280;
`endif

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       enable = 1'b0;
  logic [P_NUM_CH*P_CH_W-1:0] ch_level = '0;
  logic [P_NUM_CH-1:0]        left_en = '0;
  logic [P_NUM_CH-1:0]        right_en = '0;
  logic [2:0]                 left_vol = '0;
  logic [2:0]                 right_vol = '0;
  logic                       sample_ready = 1'b0;
  logic [2:0]                 fs_step;
  logic                       length_tick, sweep_tick, envelope_tick;
  logic [P_OUT_W-1:0]         sample_left, sample_right;
  logic                       sample_valid;
  logic                       overrun;

  apu_mix_sequencer #(
    .NUM_CH(P_NUM_CH), .CH_W(P_CH_W), .FS_DIV(P_FS_DIV),
    .SAMPLE_DIV(P_SAMPLE_DIV), .OUT_W(P_OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_level(ch_level),
    .left_en(left_en), .right_en(right_en), .left_vol(left_vol), .right_vol(right_vol),
    .fs_step(fs_step), .length_tick(length_tick), .sweep_tick(sweep_tick),
    .envelope_tick(envelope_tick), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mix rule from plain arithmetic: sum routed levels, times (vol+1), MSB-justify.
  function automatic logic [15:0] mix_expect(input logic [15:0] lv, input logic [3:0] en,
                                             input logic [2:0] vol, input logic ena);
    int sum;
    int v;
    logic [15:0] r;
    sum = 0;
    for (int i = 0; i < P_NUM_CH; i++) begin
      if (en[i]) sum += int'(lv[i*P_CH_W +: P_CH_W]);
    end
    v = sum * (int'(vol) + 1) * (1 << (P_OUT_W - SW));
    if (!ena) v = 0;
    r = v[15:0];
`ifdef APU_SIGNED_OUT_EN
    r[15] = ~r[15];
`endif
    return r;
  endfunction

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } samp_t;
  samp_t sb_q[$];

  // Reference model: evaluated on the falling edge with the inputs of the current cycle.
  bit m_ok = 0;
  int e_run = 0;      // consecutive enabled cycles before this one
  int since_rst = 0;  // cycles since reset released
  int cyc = 0;
  int m_vfrom = 0;
  bit m_busy = 0;
  bit m_ovr = 0;

  always @(negedge clk) begin : model
    int  exp_step;
    bit  exp_tk, tick, vnow;
    samp_t s;
    exp_step = (e_run / P_FS_DIV) % 8;
    exp_tk   = (e_run > 0) && (e_run % P_FS_DIV == 0);
    vnow     = m_busy && (cyc >= m_vfrom);
    if (m_ok) begin
      check("fs_step", 32'(fs_step), 32'(exp_step));
      check("length_tick", 32'(length_tick), 32'(exp_tk && (exp_step % 2 == 0)));
      check("sweep_tick", 32'(sweep_tick), 32'(exp_tk && (exp_step == 2 || exp_step == 6)));
      check("envelope_tick", 32'(envelope_tick), 32'(exp_tk && exp_step == 7));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("sample_valid", 32'(sample_valid), 32'(vnow));
    end
    if (reset) begin
      e_run = 0; since_rst = 0; m_busy = 0; m_ovr = 0;
      sb_q.delete();
      m_ok = 1;
    end else if (m_ok) begin
      tick = (since_rst % P_SAMPLE_DIV) == (P_SAMPLE_DIV - 1);
      since_rst++;
      e_run = enable ? e_run + 1 : 0;
      if (vnow && sample_ready) m_busy = 0;
      if (tick) begin
        if (!m_busy) begin
          s.l = mix_expect(ch_level, left_en, left_vol, enable);
          s.r = mix_expect(ch_level, right_en, right_vol, enable);
          sb_q.push_back(s);
          m_busy  = 1;
          m_vfrom = cyc + P_NUM_CH + 2;
        end else begin
          m_ovr = 1;
        end
      end
    end
    cyc++;
  end

  // Monitor: presented data must match the oldest expected sample while valid; pop on transfer.
  always @(negedge clk) begin : monitor
    if (m_ok && !reset && sample_valid) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        check("sample_left", 32'(sample_left), 32'(sb_q[0].l));
        check("sample_right", 32'(sample_right), 32'(sb_q[0].r));
        if (sample_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        n = i;
        break;
      end
    end
    check("valid_timeout", 32'(n >= 0), 32'd1);
  endtask

  initial begin
    int n;
    int len_cnt, swp_cnt, env_cnt;

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_left", 32'(sample_left), 32'd0);
    check("rst_right", 32'(sample_right), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_fs_step", 32'(fs_step), 32'd0);
    next_cycle();
    next_cycle();

    // Frame sequencer: 32 enabled cycles, then drop enable
    len_cnt = 0; swp_cnt = 0; env_cnt = 0;
    enable = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i == 32) enable = 1'b0;
      @(negedge clk);
      len_cnt += int'(length_tick);
      swp_cnt += int'(sweep_tick);
      env_cnt += int'(envelope_tick);
      if (i == 4)  check("fs_first_step", 32'(fs_step), 32'd1);
      if (i == 31) check("fs_step7", 32'(fs_step), 32'd7);
      next_cycle();
    end
    @(negedge clk);
    check("fs_off_step", 32'(fs_step), 32'd0);
    check("fs_off_tick", 32'({length_tick, sweep_tick, envelope_tick}), 32'd0);
    check("len_count", 32'(len_cnt), 32'd4);
    check("sweep_count", 32'(swp_cnt), 32'd2);
    check("env_count", 32'(env_cnt), 32'd1);
    next_cycle();

    // Full-scale left, silent right
    enable = 1'b1; ch_level = 16'hFFFF; left_en = 4'hF; left_vol = 3'd7;
    right_en = 4'h0; right_vol = 3'd0; sample_ready = 1'b1;
    do_reset();
    wait_valid(n);
    check("fullscale_left", 32'(sample_left), 32'(EXP_A_L));
    check("fullscale_right", 32'(sample_right), 32'(EXP_A_R));
    next_cycle();

    // Single channel, right only; first valid at tick (cycle 7) + NUM_CH + 2
    ch_level = 16'h0005; left_en = 4'h0; right_en = 4'b0001; right_vol = 3'd0;
    do_reset();
    wait_valid(n);
    check("latency", 32'(n), 32'd13);
    check("ch0_right", 32'(sample_right), 32'(EXP_B_R));
    check("ch0_left", 32'(sample_left), 32'(EXP_B_L));
    next_cycle();

    // Stalled consumer: overrun, held sample, single transfer
    ch_level = 16'(($urandom)); left_en = 4'hF; right_en = 4'h5; left_vol = 3'd3; right_vol = 3'd6;
    sample_ready = 1'b0;
    do_reset();
    repeat (20) next_cycle();
    sample_ready = 1'b1;
    @(negedge clk);
    check("stall_overrun", 32'(overrun), 32'd1);
    check("stall_valid", 32'(sample_valid), 32'd1);
    next_cycle();
    sample_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(sample_valid), 32'd0);
    next_cycle();

    // Ready on the exact tick cycle while holding
    ch_level = 16'hFFFF; left_en = 4'hF; left_vol = 3'd7;
    sample_ready = 1'b0;
    do_reset();
    repeat (15) next_cycle();
    sample_ready = 1'b1;
    next_cycle();
    sample_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    check("sametick_overrun", 32'(overrun), 32'd0);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("sametick_valid_early", 32'(sample_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("sametick_valid", 32'(sample_valid), 32'd1);
    next_cycle();

    // Reset during accumulation
    sample_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("rst_clears_left", 32'(sample_left), 32'd0);
    next_cycle();
    repeat (8) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(sample_valid), 32'd0);
    check("abort_left", 32'(sample_left), 32'd0);
    check("abort_right", 32'(sample_right), 32'd0);
    n = 0;
    repeat (12) begin
      next_cycle();
      @(negedge clk);
      n += int'(sample_valid);
    end
    check("abort_no_sample", 32'(n), 32'd0);
    next_cycle();

    // Randomized traffic
    enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      ch_level     = 16'($urandom);
      left_en      = 4'($urandom);
      right_en     = 4'($urandom);
      left_vol     = 3'($urandom);
      right_vol    = 3'($urandom);
      sample_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      reset = ($urandom_range(0, 399) == 0);
      next_cycle();
    end
    reset = 1'b0;
    sample_ready = 1'b1;
    repeat (3 * P_SAMPLE_DIV) next_cycle();
    check("sb_drain", 32'(sb_q.size() <= 1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apu_mix_sequencer.md
# apu_mix_sequencer

Parametrised frame sequencer and stereo mixer for the Game Boy audio path. It generates the 512 Hz frame-sequencer step and its length, sweep and envelope tick pulses for all channel generators. At the AC97 frame rate it snapshots NUM_CH channel levels, routes each to the left (SO2) and right (SO1) buses, applies the master volumes, and presents one stereo sample per frame through a valid/ready handshake to the AC97 slot formatter. It replaces the fixed clock-divider pair and single-channel level path with a configurable-channel-count block.

## Interface
Parameters:
- NUM_CH, 4, number of channel inputs (1..8)
- CH_W, 4, width of one channel level (unsigned)
- FS_DIV, 24000, clk cycles per frame-sequencer step (12.288 MHz / 512 Hz)
- SAMPLE_DIV, 256, clk cycles per output sample (48 kHz)
- OUT_W, 16, output sample width; must be ≥ SW = CH_W + clog2(NUM_CH) + 3

Ports:
- clk  in  1  bit clock (ac97_bitclk domain)
- reset  in  1  synchronous, active-high
- enable  in  1  sound master enable (NR52 bit 7)
- ch_level  in  NUM_CH*CH_W  channel levels, channel i at [i*CH_W +: CH_W]
- left_en  in  NUM_CH  per-channel SO2 routing
- right_en  in  NUM_CH  per-channel SO1 routing
- left_vol  in  3  SO2 master volume, gain = left_vol+1
- right_vol  in  3  SO1 master volume, gain = right_vol+1
- fs_step  out  3  current frame-sequencer step
- length_tick  out  1  one-cycle pulse, 256 Hz
- sweep_tick  out  1  one-cycle pulse, 128 Hz
- envelope_tick  out  1  one-cycle pulse, 64 Hz
- sample_left  out  OUT_W  left sample
- sample_right  out  OUT_W  right sample
- sample_valid  out  1  sample pair valid
- sample_ready  in  1  consumer accepts sample pair
- overrun  out  1  sticky: a sample tick was dropped

## Operation
- Frame sequencer: divider counts 0..FS_DIV-1 and wraps. On the wrap cycle, fs_step advances mod 8 on the next edge, and the ticks are registered from the new step in that same edge: length_tick on even steps (0,2,4,6), sweep_tick on steps 2 and 6, envelope_tick on step 7.
- While enable=0, the divider and fs_step are held at 0 and no ticks are issued. When enable rises, counting starts from 0.
- The sample divider counts 0..SAMPLE_DIV-1 and runs regardless of enable. Its wrap cycle is the sample tick.
- Mixer FSM:
  - IDLE: on sample tick, snapshot ch_level, left_en, right_en, left_vol and right_vol, then go to ACCUM.
  - ACCUM: spend NUM_CH cycles. Channel i is added to sumL if left_en[i] and to sumR if right_en[i]. Sums are clog2(NUM_CH)+CH_W bits wide and cannot overflow.
  - SCALE: one cycle. Compute scaled = sum × (vol+1), SW bits wide. Compute out = scaled << (OUT_W−SW), which is unsigned and MSB-justified. If enable=0 in the snapshot, out = 0.
  - HOLD: sample_valid=1 and outputs are stable. Transfer occurs when sample_valid && sample_ready. Then go to IDLE.
- A sample tick in ACCUM, SCALE, or HOLD without a transfer is dropped and sets overrun. overrun clears only on reset.
- A sample tick in the same cycle as a HOLD transfer is not dropped. The snapshot is taken and the FSM enters ACCUM directly.
- Reset mid-operation aborts any accumulation. No partial sample is presented.

## Timing
- Reset values: fs_step=0, all ticks=0, sample_left=sample_right=0, sample_valid=0, overrun=0, FSM=IDLE, both dividers=0.
- Sample latency: tick at cycle T → ACCUM T+1..T+NUM_CH → SCALE T+NUM_CH+1 → sample_valid=1 from T+NUM_CH+2.
- sample_valid, once high, stays high with stable data until transfer. It drops the cycle after the transfer.
- Ticks last exactly one clk cycle and are mutually coincident where steps overlap, e.g. step 2 gives length_tick and sweep_tick together.
- First tick after reset with enable=1: fs_step=1 at cycle FS_DIV, no tick pulses. The first length_tick occurs at cycle 2·FS_DIV.

## Configuration
- APU_SIGNED_OUT_EN defined: outputs are two's complement, formed by inverting the MSB of the unsigned result. Silence (or enable=0) outputs 0 before inversion, i.e. 1 << (OUT_W−1) after.
- APU_SIGNED_OUT_EN undefined: outputs are unsigned as described above. Silence outputs 0.

## Test plan
- Defaults, all levels 15, left_en=4'hF, left_vol=7, right_en=0, sample_ready=1 → sample_left=16'hF000, sample_right=16'h0000; with APU_SIGNED_OUT_EN, 16'h7000 and 16'h8000.
- Only ch0=5, right_en=4'b0001, right_vol=0 → sample_right=16'h0280. sample_valid rises 6 cycles after the sample tick.
- FS_DIV=4, enable=1 for 32 cycles → fs_step runs 1..7,0; 4 length_ticks, 2 sweep_ticks, 1 envelope_tick. Drop enable → fs_step=0 next cycle and no further ticks.
- SAMPLE_DIV=8, sample_ready=0 for 20 cycles → overrun=1 and the first sample is held unchanged. Raise sample_ready → one transfer, and sample_valid falls the next cycle.
- Assert sample_ready on the exact cycle of the next sample tick while in HOLD → no overrun, and a new sample_valid appears NUM_CH+2 cycles later.
- Assert reset during ACCUM → all outputs return to reset values the next cycle, and no sample is emitted.
